frame_deserializer: RTL and testbench
=====================================

FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame (legal range 5..16).
REQ-002 Parameter PARITY_MODE, default 1, parity bit handling: 0 none, 1 odd, 2 even.
REQ-003 Parameter MSB_FIRST, default 0, data bit order: 0 LSB first, 1 MSB first.
REQ-004 Parameter TIMEOUT_CYCLES, default 2000, FCLK cycles allowed between serial clock falls inside a frame.
REQ-005 FCLK  input  1  system clock, all state on rising edge.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 CONTROL_CLOCK  input  1  external serial clock, asynchronous to FCLK.
REQ-008 DEBOUNCED_DATA  input  1  external serial data, asynchronous to FCLK.
REQ-009 DATA_READY  input  1  consumer accepts held word when high with DATA_VALID.
REQ-010 PARALLEL_DATA_OUTPUT  output  DATA_WIDTH  last accepted frame payload.
REQ-011 DATA_VALID  output  1  PARALLEL_DATA_OUTPUT holds an unconsumed word.
REQ-012 OUTPUT_COUNTER_REGISTER  output  $clog2(DATA_WIDTH+3)  bits received in the current frame.
REQ-013 BUSY  output  1  high in any state other than IDLE.
REQ-014 PARITY_ERROR, FRAMING_ERROR, TIMEOUT_ERROR, OVERRUN  output  1 each  single-cycle error pulses.

Function
REQ-015 CONTROL_CLOCK and DEBOUNCED_DATA shall each pass through a 2-flop synchronizer; a fall is sync_prev=1 and sync=0, and the data sample is the synchronized data on that same FCLK cycle.
REQ-016 Frame: start bit 0, DATA_WIDTH data bits, one parity bit when PARITY_MODE is not 0, stop bit 1; one bit per CONTROL_CLOCK fall.
REQ-017 FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on a fall sampling 0; a fall sampling 1 in IDLE is ignored with no error.
REQ-018 DATA->PARITY (or STOP when PARITY_MODE=0) after DATA_WIDTH data falls; PARITY->STOP after one fall; STOP->IDLE on the next fall.
REQ-019 Data bits are assembled LSB-first into bit 0 upward when MSB_FIRST=0, and MSB-first into bit DATA_WIDTH-1 downward when MSB_FIRST=1.
REQ-020 OUTPUT_COUNTER_REGISTER increments on every fall outside IDLE, counts the start bit as 1, and returns to 0 on entry to IDLE.
REQ-021 Parity check: odd mode requires an odd count of ones over data+parity; even mode requires an even count.
REQ-022 Stop fall sampling 1 with good parity: the word is accepted; PARALLEL_DATA_OUTPUT loads and DATA_VALID rises on the FCLK edge after the stop fall is detected (1-cycle latency).
REQ-023 Parity mismatch: the frame is discarded and PARITY_ERROR pulses with the stop fall; if the stop bit is also 0, FRAMING_ERROR pulses in the same cycle.
REQ-024 Stop bit sampled 0: the frame is discarded and FRAMING_ERROR pulses.
REQ-025 DATA_VALID holds, with PARALLEL_DATA_OUTPUT stable, until DATA_VALID and DATA_READY are both high on an FCLK edge, then clears.
REQ-026 A good frame completing while DATA_VALID=1 and DATA_READY=0 is dropped, the held word is kept, and OVERRUN pulses.
REQ-027 A good frame completing on the same cycle that the held word is consumed is loaded, and DATA_VALID stays high.
REQ-028 Timeout counter clears on every fall and in IDLE; on reaching TIMEOUT_CYCLES-1 outside IDLE, the FSM returns to IDLE, the partial frame is discarded, and TIMEOUT_ERROR pulses.

Reset
REQ-029 While RST_N=0: FSM in IDLE; counters, synchronizers (to 1), shift register, and PARALLEL_DATA_OUTPUT cleared; DATA_VALID, BUSY, and all error outputs 0.
REQ-030 Reset asserted mid-frame aborts the frame with no error pulse; after RST_N rises, the first frame requires a fresh start bit.

Structure
REQ-031 Package frame_deserializer_pkg shall hold the FSM state enum and the PARITY_NONE/ODD/EVEN constants.
REQ-032 Sub-module sync_fall_detect (2-flop synchronizer plus fall detector) is instantiated twice: for the clock with edge output, for the data with level output.

Verification
REQ-033 DATA_WIDTH=8, odd parity, LSB first, frame 0x5A (parity 1, stop 1), DATA_READY=1 -> output 0x5A, DATA_VALID high 1 cycle, no error.
REQ-034 Same frame with parity bit 0 -> PARITY_ERROR pulses once, DATA_VALID stays 0, counter returns to 0.
REQ-035 DATA_READY=0, frames 0x11 then 0x22 -> output stays 0x11, OVERRUN pulses at end of the 0x22 frame; DATA_READY=1 then clears DATA_VALID.
REQ-036 TIMEOUT_CYCLES=50, clock stopped after 4 bits -> TIMEOUT_ERROR 50 cycles after the last fall, BUSY=0; next full frame 0xA5 is received correctly.
REQ-037 MSB_FIRST=1, DATA_WIDTH=12, PARITY_MODE=0, bits of 0xC3F -> output 0xC3F; stop bit 0 variant -> FRAMING_ERROR.
REQ-038 RST_N pulsed low after 5 bits of a frame -> all outputs 0, no error pulse; next frame 0x3C is received correctly.

Source files
------------

// File: rtl/frame_deserializer_pkg.sv
// Shared types and constants for the serial frame deserializer.
package frame_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/sync_fall_detect.sv
// Two-flop synchronizer with a trailing flop for falling-edge detection.
// EDGE_OUT selects whether sig_out is the fall strobe or the synchronized level.
module sync_fall_detect #(
  parameter bit EDGE_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sig_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Reset to 1 so an idle-high line never produces a spurious fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sig_out = EDGE_OUT ? (prev_q & ~sync_q) : sync_q;

endmodule

// File: rtl/frame_deserializer.sv
// Receives start/data/parity/stop frames clocked by an external serial clock
// and presents the payload with a valid/ready hold register and error pulses.
module frame_deserializer
  import frame_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_MODE    = 1,
  parameter int MSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                            FCLK,
  input  logic                            RST_N,
  input  logic                            CONTROL_CLOCK,
  input  logic                            DEBOUNCED_DATA,
  input  logic                            DATA_READY,
  output logic [DATA_WIDTH-1:0]           PARALLEL_DATA_OUTPUT,
  output logic                            DATA_VALID,
  output logic [$clog2(DATA_WIDTH+3)-1:0] OUTPUT_COUNTER_REGISTER,
  output logic                            BUSY,
  output logic                            PARITY_ERROR,
  output logic                            FRAMING_ERROR,
  output logic                            TIMEOUT_ERROR,
  output logic                            OVERRUN
);

  localparam int CW = $clog2(DATA_WIDTH + 3);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  par_q, par_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  toerr_q, toerr_d;
  logic                  ovr_q, ovr_d;

  logic fall;
  logic bit_in;
  logic timeout_hit;
  logic par_ok;

  sync_fall_detect #(.EDGE_OUT(1'b1)) u_clk_sync (
    .clk     (FCLK),
    .rst_n   (RST_N),
    .async_in(CONTROL_CLOCK),
    .sig_out (fall)
  );

  sync_fall_detect #(.EDGE_OUT(1'b0)) u_data_sync (
    .clk     (FCLK),
    .rst_n   (RST_N),
    .async_in(DEBOUNCED_DATA),
    .sig_out (bit_in)
  );

  // A fall arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = (state_q != ST_IDLE) && !fall &&
                       (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign par_ok = (PARITY_MODE == PARITY_NONE) ||
                  (par_q == (PARITY_MODE == PARITY_ODD));

  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall && !bit_in) state_d = ST_DATA;
      ST_DATA:   if (fall && cnt_q == CW'(DATA_WIDTH))
                   state_d = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (fall) state_d = ST_STOP;
      ST_STOP:   if (fall) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (timeout_hit) state_d = ST_IDLE;
  end

  always_comb begin
    cnt_d   = cnt_q;
    timer_d = timer_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    par_d   = par_q;
    valid_d = valid_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    toerr_d = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && DATA_READY) valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      timer_d = '0;
      cnt_d   = '0;
      if (fall && !bit_in) begin
        cnt_d = CW'(1);
        par_d = 1'b0;
      end
    end else if (fall) begin
      timer_d = '0;
      cnt_d   = cnt_q + CW'(1);
      case (state_q)
        ST_DATA: begin
          par_d = par_q ^ bit_in;
          if (MSB_FIRST != 0) shift_d = {shift_q[DATA_WIDTH-2:0], bit_in};
          else                shift_d = {bit_in, shift_q[DATA_WIDTH-1:1]};
        end
        ST_PARITY: par_d = par_q ^ bit_in;
        ST_STOP: begin
          cnt_d  = '0;
          perr_d = !par_ok;
          ferr_d = !bit_in;
          if (par_ok && bit_in) begin
            // Held word survives unless it is being consumed this very cycle.
            if (valid_q && !DATA_READY) begin
              ovr_d = 1'b1;
            end else begin
              dout_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      timer_d = '0;
      cnt_d   = '0;
      toerr_d = 1'b1;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      timer_q <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      toerr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      toerr_q <= toerr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    BUSY                    = (state_q != ST_IDLE);
    PARALLEL_DATA_OUTPUT    = dout_q;
    DATA_VALID              = valid_q;
    OUTPUT_COUNTER_REGISTER = cnt_q;
    PARITY_ERROR            = perr_q;
    FRAMING_ERROR           = ferr_q;
    TIMEOUT_ERROR           = toerr_q;
    OVERRUN                 = ovr_q;
  end

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboard bench: dut 0 is 8-bit odd parity LSB-first with a short timeout,
// dut 1 is 12-bit no parity MSB-first with the default timeout.
module tb_frame_deserializer;

  typedef struct packed {
    logic        is_word;
    logic [3:0]  err;     // {parity, framing, timeout, overrun}
    logic [15:0] data;
  } ev_t;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        cclk [2];
  logic        cdat [2];
  logic        rdy  [2];
  logic [7:0]  dout_a;
  logic [11:0] dout_b;
  logic [3:0]  cnt_a, cnt_b;
  logic        valid[2], busy[2], perr[2], ferr[2], toe[2], ovr[2];

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc = 0;
  int unsigned last_fall[2];
  int unsigned to_cyc[2];
  int          vhi[2];
  logic        pv[2], pr[2];
  bit          held[2];
  ev_t         q0[$], q1[$];

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  frame_deserializer #(.DATA_WIDTH(8), .PARITY_MODE(1), .MSB_FIRST(0),
                       .TIMEOUT_CYCLES(50)) dut_a (
    .FCLK(fclk), .RST_N(rst_n), .CONTROL_CLOCK(cclk[0]), .DEBOUNCED_DATA(cdat[0]),
    .DATA_READY(rdy[0]), .PARALLEL_DATA_OUTPUT(dout_a), .DATA_VALID(valid[0]),
    .OUTPUT_COUNTER_REGISTER(cnt_a), .BUSY(busy[0]), .PARITY_ERROR(perr[0]),
    .FRAMING_ERROR(ferr[0]), .TIMEOUT_ERROR(toe[0]), .OVERRUN(ovr[0]));

  frame_deserializer #(.DATA_WIDTH(12), .PARITY_MODE(0), .MSB_FIRST(1)) dut_b (
    .FCLK(fclk), .RST_N(rst_n), .CONTROL_CLOCK(cclk[1]), .DEBOUNCED_DATA(cdat[1]),
    .DATA_READY(rdy[1]), .PARALLEL_DATA_OUTPUT(dout_b), .DATA_VALID(valid[1]),
    .OUTPUT_COUNTER_REGISTER(cnt_b), .BUSY(busy[1]), .PARITY_ERROR(perr[1]),
    .FRAMING_ERROR(ferr[1]), .TIMEOUT_ERROR(toe[1]), .OVERRUN(ovr[1]));

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic match(input int d, input ev_t got);
    ev_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_event_dut%0d: got 0x%0h expected none", d, got);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("event_dut%0d", d), longint'(got), longint'(e));
    end
  endtask

  task automatic push(input int d, input ev_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every error pulse and every newly presented word is one event.
  always @(negedge fclk) begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0]  e;
      logic [15:0] dv;
      e  = {perr[d], ferr[d], toe[d], ovr[d]};
      dv = (d == 0) ? {8'h00, dout_a} : {4'h0, dout_b};
      if (toe[d]) to_cyc[d] = cyc;
      if (valid[d]) vhi[d]++;
      if (rst_n) begin
        if (e != 4'h0) match(d, {1'b0, e, 16'h0000});
        if (valid[d] && (!pv[d] || pr[d])) match(d, {1'b1, 4'h0, dv});
      end
      pv[d] = valid[d];
      pr[d] = rdy[d];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge fclk);
    #2;
  endtask

  task automatic send_bit(input int d, input logic b);
    cdat[d] = b;
    tick(4);
    cclk[d]      = 1'b0;
    last_fall[d] = cyc;
    tick(4);
    cclk[d] = 1'b1;
  endtask

  // Reference: payload is the value whose bits were sent; parity/stop/hold rules decide the event.
  task automatic expect_frame(input int d, input logic [15:0] data, input logic pbit,
                              input logic stopb);
    int   ones;
    logic par_ok;
    ones   = $countones(data);
    par_ok = (d == 1) || (((ones + int'(pbit)) % 2) == 1);
    if (!par_ok || !stopb)          push(d, {1'b0, ~par_ok, ~stopb, 2'b00, 16'h0000});
    else if (held[d] && !rdy[d])    push(d, {1'b0, 4'b0001, 16'h0000});
    else begin
      push(d, {1'b1, 4'h0, data});
      held[d] = !rdy[d];
    end
  endtask

  task automatic send_frame(input int d, input logic [15:0] data, input logic pbit,
                            input logic stopb);
    int w;
    w = (d == 0) ? 8 : 12;
    expect_frame(d, data, pbit, stopb);
    send_bit(d, 1'b0);
    for (int i = 0; i < w; i++) send_bit(d, (d == 0) ? data[i] : data[w-1-i]);
    if (d == 0) send_bit(d, pbit);
    send_bit(d, stopb);
    tick(4);
  endtask

  function automatic logic odd_par(input logic [15:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  initial begin
    int   v0;
    logic [15:0] r;
    logic p, s;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cclk[d] = 1'b1; cdat[d] = 1'b1; rdy[d] = 1'b1; held[d] = 1'b0; to_cyc[d] = 0;
    end
    tick(5);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_valid_a", valid[0], 0);
    chk("rst_busy_a", busy[0], 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_err_a", {perr[0], ferr[0], toe[0], ovr[0]}, 0);
    chk("rst_dout_b", dout_b, 0);
    rst_n = 1'b1;
    tick(5);

    // Good frame 0x5A, ready high: one word, valid for exactly one cycle.
    v0 = vhi[0];
    send_frame(0, 16'h005A, 1'b1, 1'b1);
    chk("t1_dout", dout_a, 8'h5A);
    chk("t1_valid_cycles", vhi[0] - v0, 1);
    chk("t1_cnt_idle", cnt_a, 0);

    // Same frame with wrong parity bit.
    v0 = vhi[0];
    send_frame(0, 16'h005A, 1'b0, 1'b1);
    chk("t2_valid_cycles", vhi[0] - v0, 0);
    chk("t2_cnt_idle", cnt_a, 0);

    // Overrun: second frame dropped while first word is held.
    rdy[0] = 1'b0;
    send_frame(0, 16'h0011, odd_par(16'h0011), 1'b1);
    send_frame(0, 16'h0022, odd_par(16'h0022), 1'b1);
    chk("t3_dout_held", dout_a, 8'h11);
    chk("t3_valid_held", valid[0], 1);
    rdy[0] = 1'b1;
    held[0] = 1'b0;
    tick(2);
    chk("t3_valid_cleared", valid[0], 0);

    // Timeout after start + 3 data bits; latency = 3 sync/detect edges + TIMEOUT_CYCLES.
    push(0, {1'b0, 4'b0010, 16'h0000});
    to_cyc[0] = 0;
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    for (int n = 0; n < 200 && to_cyc[0] == 0; n++) tick(1);
    chk("t4_timeout_latency", longint'(to_cyc[0]) - longint'(last_fall[0]), 53);
    chk("t4_busy", busy[0], 0);
    chk("t4_cnt", cnt_a, 0);
    send_frame(0, 16'h00A5, odd_par(16'h00A5), 1'b1);
    chk("t4_dout_after", dout_a, 8'hA5);

    // 12-bit MSB-first, no parity; then bad stop bit.
    send_frame(1, 16'h0C3F, 1'b0, 1'b1);
    chk("t5_dout_b", dout_b, 12'hC3F);
    send_frame(1, 16'h0C3F, 1'b0, 1'b0);
    chk("t5_cnt_b", cnt_b, 0);

    // Reset mid-frame after 5 bits: no error, outputs cleared.
    for (int i = 0; i < 5; i++) send_bit(0, (i == 0) ? 1'b0 : 1'b1);
    chk("t6_busy_before", busy[0], 1);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst_busy", busy[0], 0);
    chk("t6_rst_cnt", cnt_a, 0);
    chk("t6_rst_dout", dout_a, 0);
    chk("t6_rst_valid", valid[0], 0);
    chk("t6_rst_dout_b", dout_b, 0);
    tick(2);
    rst_n = 1'b1;
    held[0] = 1'b0;
    held[1] = 1'b0;
    tick(3);
    send_frame(0, 16'h003C, odd_par(16'h003C), 1'b1);
    chk("t6_dout_after", dout_a, 8'h3C);

    // Randomized frames with random ready, parity and stop faults.
    for (int i = 0; i < 30; i++) begin
      rdy[0] = ($urandom_range(0, 3) != 0);
      if (rdy[0]) held[0] = 1'b0;
      tick(2);
      r = 16'($urandom) & 16'h00FF;
      p = odd_par(r) ^ ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 7) != 0);
      send_frame(0, r, p, s);
    end
    for (int i = 0; i < 15; i++) begin
      rdy[1] = ($urandom_range(0, 3) != 0);
      if (rdy[1]) held[1] = 1'b0;
      tick(2);
      r = 16'($urandom) & 16'h0FFF;
      s = ($urandom_range(0, 5) != 0);
      send_frame(1, r, 1'b0, s);
    end
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    tick(10);
    chk("end_busy_a", busy[0], 0);
    chk("end_busy_b", busy[1], 0);
    chk("end_pending_a", q0.size(), 0);
    chk("end_pending_b", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
